sme_host: RTL and testbench

- Initiator for the string match engine (SME).
- A local controller writes a search string and a pattern into on-chip buffers. On `start`, the block streams them to the SME over the `isstring`/`ispattern`/`chardata` protocol.
- It then waits for the SME result pulse (`out_valid`/`match`/`match_index`) and presents it to the controller as a registered result with a completion strobe and a watchdog timeout.

---
 rtl/sme_host.sv | 256 +++++++++++++++++++++++++
 tb/tb_sme_host.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sme_host.sv
// sme_host: buffers a string and a pattern, streams them to the string match
// engine on start, then returns its result or a watchdog timeout.
// Ports: clk, rst_n, wr_en, wr_sel, wr_data and start come from the controller.
// busy, ovf and res_* go back to the controller. isstring, ispattern and
// chardata drive the SME, and sme_out_valid, sme_match, sme_match_index
// come back from it.
module sme_host #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic       wr_sel,
  input  logic [7:0] wr_data,
  input  logic       start,
  output logic       busy,
  output logic       ovf,
  output logic       isstring,
  output logic       ispattern,
  output logic [7:0] chardata,
  input  logic       sme_out_valid,
  input  logic       sme_match,
  input  logic [4:0] sme_match_index,
  output logic       res_valid,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_timeout
);

  localparam int SAW = $clog2(STR_MAX);
  localparam int PAW = $clog2(PAT_MAX);
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_STR, S_PAT, S_WAIT, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [7:0] str_mem [STR_MAX];
  logic [7:0] pat_mem [PAT_MAX];

  logic [5:0]     idx_q, idx_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [5:0]     str_len_q, str_len_d;
  logic [3:0]     pat_len_q, pat_len_d;
  logic           new_str_q, new_str_d;
  // Set by a start: the next write to that class begins a fresh buffer.
  logic           str_rst_q, str_rst_d;
  logic           pat_rst_q, pat_rst_d;
  logic           ovf_q, ovf_d;
  logic           busy_q, busy_d;
  logic           iss_q, iss_d;
  logic           isp_q, isp_d;
  logic [7:0]     chr_q, chr_d;
  logic           rv_q, rv_d;
  logic           rm_q, rm_d;
  logic [4:0]     ri_q, ri_d;
  logic           rt_q, rt_d;

  logic           str_we, pat_we;
  logic [SAW-1:0] str_wa;
  logic [PAW-1:0] pat_wa;
  logic [5:0]     idx_nx;

  assign idx_nx = idx_q + 6'd1;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wd_d      = wd_q;
    str_len_d = str_len_q;
    pat_len_d = pat_len_q;
    new_str_d = new_str_q;
    str_rst_d = str_rst_q;
    pat_rst_d = pat_rst_q;
    ovf_d     = ovf_q;
    busy_d    = busy_q;
    iss_d     = 1'b0;
    isp_d     = 1'b0;
    chr_d     = 8'd0;
    rv_d      = 1'b0;
    rm_d      = rm_q;
    ri_d      = ri_q;
    rt_d      = rt_q;
    str_we    = 1'b0;
    pat_we    = 1'b0;
    str_wa    = '0;
    pat_wa    = '0;

    if (wr_en && !busy_q) begin
      if (!wr_sel) begin
        if (str_rst_q) begin
          str_we    = 1'b1;
          str_len_d = 6'd1;
          str_rst_d = 1'b0;
          new_str_d = 1'b1;
        end else if (str_len_q == 6'(STR_MAX)) begin
          ovf_d = 1'b1;
        end else begin
          str_we    = 1'b1;
          str_wa    = str_len_q[SAW-1:0];
          str_len_d = str_len_q + 6'd1;
          new_str_d = 1'b1;
        end
      end else begin
        if (pat_rst_q) begin
          pat_we    = 1'b1;
          pat_len_d = 4'd1;
          pat_rst_d = 1'b0;
        end else if (pat_len_q == 4'(PAT_MAX)) begin
          ovf_d = 1'b1;
        end else begin
          pat_we    = 1'b1;
          pat_wa    = pat_len_q[PAW-1:0];
          pat_len_d = pat_len_q + 4'd1;
        end
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ovf_d     = 1'b0;
          new_str_d = 1'b0;
          str_rst_d = 1'b1;
          pat_rst_d = 1'b1;
          busy_d    = 1'b1;
          rm_d      = 1'b0;
          ri_d      = 5'd0;
          rt_d      = 1'b0;
          idx_d     = 6'd0;
          if (pat_len_q == 4'd0) begin
            state_d = S_DONE;
            rv_d    = 1'b1;
            rt_d    = 1'b1;
          end else if (new_str_q && str_len_q != 6'd0) begin
            state_d = S_STR;
            iss_d   = 1'b1;
            chr_d   = str_mem[0];
          end else begin
            state_d = S_PAT;
            isp_d   = 1'b1;
            chr_d   = pat_mem[0];
          end
        end
      end
      S_STR: begin
        if (idx_nx < str_len_q) begin
          idx_d = idx_nx;
          iss_d = 1'b1;
          chr_d = str_mem[idx_nx[SAW-1:0]];
        end else begin
          state_d = S_PAT;
          idx_d   = 6'd0;
          isp_d   = 1'b1;
          chr_d   = pat_mem[0];
        end
      end
      S_PAT: begin
        if (idx_nx < {2'b00, pat_len_q}) begin
          idx_d = idx_nx;
          isp_d = 1'b1;
          chr_d = pat_mem[idx_nx[PAW-1:0]];
        end else begin
          state_d = S_WAIT;
          wd_d    = '0;
        end
      end
      S_WAIT: begin
        // A result in the expiry cycle still beats the watchdog.
        if (sme_out_valid) begin
          state_d = S_DONE;
          rv_d    = 1'b1;
          rm_d    = sme_match;
          ri_d    = sme_match_index;
          rt_d    = 1'b0;
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          state_d = S_DONE;
          rv_d    = 1'b1;
          rm_d    = 1'b0;
          ri_d    = 5'd0;
          rt_d    = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (str_we) str_mem[str_wa] <= wr_data;
    if (pat_we) pat_mem[pat_wa] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      wd_q      <= '0;
      str_len_q <= '0;
      pat_len_q <= '0;
      new_str_q <= 1'b0;
      str_rst_q <= 1'b0;
      pat_rst_q <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      iss_q     <= 1'b0;
      isp_q     <= 1'b0;
      chr_q     <= '0;
      rv_q      <= 1'b0;
      rm_q      <= 1'b0;
      ri_q      <= '0;
      rt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wd_q      <= wd_d;
      str_len_q <= str_len_d;
      pat_len_q <= pat_len_d;
      new_str_q <= new_str_d;
      str_rst_q <= str_rst_d;
      pat_rst_q <= pat_rst_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      iss_q     <= iss_d;
      isp_q     <= isp_d;
      chr_q     <= chr_d;
      rv_q      <= rv_d;
      rm_q      <= rm_d;
      ri_q      <= ri_d;
      rt_q      <= rt_d;
    end
  end

  assign busy        = busy_q;
  assign ovf         = ovf_q;
  assign isstring    = iss_q;
  assign ispattern   = isp_q;
  assign chardata    = chr_q;
  assign res_valid   = rv_q;
  assign res_match   = rm_q;
  assign res_index   = ri_q;
  assign res_timeout = rt_q;

endmodule

// File: tb/tb_sme_host.sv
// tb_sme_host: randomized self-checking bench for sme_host against a
// queue-based model of the buffers, the SME stream and the result timing.
module tb_sme_host;

  localparam int TO   = 4;
  localparam int SMAX = 32;
  localparam int PMAX = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, wr_sel, start;
  logic [7:0] wr_data;
  logic       busy, ovf, isstring, ispattern;
  logic [7:0] chardata;
  logic       sme_out_valid, sme_match;
  logic [4:0] sme_match_index;
  logic       res_valid, res_match, res_timeout;
  logic [4:0] res_index;

  int total = 0;
  int bad   = 0;

  logic [7:0] str_m[$];
  logic [7:0] pat_m[$];
  bit new_str_m, ovf_m, str_rs, pat_rs;

  always #5 clk = ~clk;

  sme_host #(
    .STR_MAX(SMAX), .PAT_MAX(PMAX), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .start(start), .busy(busy), .ovf(ovf),
    .isstring(isstring), .ispattern(ispattern),
    .chardata(chardata),
    .sme_out_valid(sme_out_valid), .sme_match(sme_match),
    .sme_match_index(sme_match_index),
    .res_valid(res_valid), .res_match(res_match),
    .res_index(res_index), .res_timeout(res_timeout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    str_m.delete();
    pat_m.delete();
    new_str_m = 0;
    ovf_m     = 0;
    str_rs    = 0;
    pat_rs    = 0;
  endtask

  task automatic wr(input bit sel, input logic [7:0] d);
    wr_en = 1; wr_sel = sel; wr_data = d;
    sme_out_valid = 1'($urandom);
    sme_match = 1; sme_match_index = 5'd7;
    step();
    wr_en = 0; sme_out_valid = 0;
    if (!sel) begin
      if (str_rs) begin str_m.delete(); str_rs = 0; end
      if (str_m.size() < SMAX) begin
        str_m.push_back(d); new_str_m = 1;
      end else ovf_m = 1;
    end else begin
      if (pat_rs) begin pat_m.delete(); pat_rs = 0; end
      if (pat_m.size() < PMAX) pat_m.push_back(d);
      else ovf_m = 1;
    end
    total++;
    if ({ovf, res_valid, busy} !== {ovf_m, 2'b00}) begin
      bad++;
      $display("FAIL wr: ovf,rv,busy=%b%b%b want %b00",
               ovf, res_valid, busy, ovf_m);
    end
  endtask

  task automatic wr_s(input bit sel, input string s);
    for (int i = 0; i < s.len(); i++) wr(sel, s[i]);
  endtask

  // One request; lat = WAIT cycle in which the SME answers (0 = never).
  task automatic run(input int lat, input bit m,
                     input logic [4:0] ix);
    logic [7:0] ec[$];
    bit es[$];
    bit err, tmo;
    int n, wmax;
    ec = {}; es = {};
    err = (pat_m.size() == 0);
    if (new_str_m)
      foreach (str_m[i]) begin
        ec.push_back(str_m[i]); es.push_back(1);
      end
    foreach (pat_m[i]) begin
      ec.push_back(pat_m[i]); es.push_back(0);
    end
    n = ec.size();
    start = 1;
    step();
    start = 0;
    ovf_m = 0; new_str_m = 0; str_rs = 1; pat_rs = 1;
    if (err) begin
      total++;
      if ({res_valid, res_timeout, res_match, res_index,
           busy, isstring, ispattern, ovf} !==
          {1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 3'b000}) begin
        bad++;
        $display("FAIL err_t1: rv,rt,rm,ri,busy,s,p,ovf=%b%b%b%0d%b%b%b%b",
                 res_valid, res_timeout, res_match, res_index,
                 busy, isstring, ispattern, ovf);
      end
      step();
      total++;
      if ({res_valid, busy, res_timeout, isstring, ispattern}
          !== 5'b00100) begin
        bad++;
        $display("FAIL err_t2: rv,busy,rt,s,p=%b%b%b%b%b want 00100",
                 res_valid, busy, res_timeout, isstring, ispattern);
      end
      return;
    end
    total++;
    if ({busy, ovf, res_valid, res_match, res_index, res_timeout}
        !== {1'b1, 9'd0}) begin
      bad++;
      $display("FAIL start_t1: busy,ovf,rv,rm,ri,rt=%b%b%b%b%0d%b",
               busy, ovf, res_valid, res_match, res_index, res_timeout);
    end
    for (int i = 0; i < n; i++) begin
      total++;
      if ({isstring, ispattern, chardata, busy} !==
          {es[i], !es[i], ec[i], 1'b1}) begin
        bad++;
        $display("FAIL stream[%0d]: s,p,c,busy=%b%b%h%b want %b%b%h1",
                 i, isstring, ispattern, chardata, busy,
                 es[i], !es[i], ec[i]);
      end
      wr_en = 1'($urandom); wr_sel = 1'($urandom);
      wr_data = 8'($urandom);
      sme_out_valid = 1'($urandom);
      step();
    end
    tmo  = (lat == 0 || lat > TO);
    wmax = tmo ? TO : lat;
    for (int j = 1; j <= wmax; j++) begin
      total++;
      if ({isstring, ispattern, chardata, res_valid, busy}
          !== {11'd0, 1'b1}) begin
        bad++;
        $display("FAIL wait[%0d]: s,p,c,rv,busy=%b%b%h%b%b", j,
                 isstring, ispattern, chardata, res_valid, busy);
      end
      wr_en = 1'($urandom); wr_sel = 1'($urandom);
      wr_data = 8'($urandom);
      sme_out_valid = (j == lat);
      sme_match = m; sme_match_index = ix;
      step();
    end
    sme_out_valid = 0; wr_en = 0;
    total++;
    if ({res_valid, res_match, res_index, res_timeout, busy} !==
        (tmo ? {1'b1, 1'b0, 5'd0, 1'b1, 1'b1}
             : {1'b1, m, ix, 1'b0, 1'b1})) begin
      bad++;
      $display("FAIL done: rv,rm,ri,rt,busy=%b%b%0d%b%b tmo=%b m=%b ix=%0d",
               res_valid, res_match, res_index, res_timeout, busy,
               tmo, m, ix);
    end
    step();
    total++;
    if ({res_valid, busy, res_match, res_index, res_timeout} !==
        (tmo ? {2'b00, 1'b0, 5'd0, 1'b1}
             : {2'b00, m, ix, 1'b0})) begin
      bad++;
      $display("FAIL after: rv,busy,rm,ri,rt=%b%b%b%0d%b",
               res_valid, busy, res_match, res_index, res_timeout);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; wr_en = 0; wr_sel = 0; wr_data = 0; start = 0;
    sme_out_valid = 0; sme_match = 0; sme_match_index = 0;
    model_reset();
    #1;
    total++;
    if ({busy, ovf, isstring, ispattern, chardata, res_valid,
         res_match, res_index, res_timeout} !== '0) begin
      bad++;
      $display("FAIL reset: outputs not zero");
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  task automatic test_err_start();
    run(1, 1'b1, 5'd3);
  endtask

  task automatic test_basic();
    wr_s(0, "abcde");
    wr_s(1, "cd");
    run(2, 1'b1, 5'd2);
  endtask

  task automatic test_pat_only();
    wr_s(1, "xy");
    run(3, 1'b0, 5'd9);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 33; i++) wr(0, 8'(8'h41 + i));
    total++;
    if (ovf !== 1'b1 || str_m.size() != SMAX) begin
      bad++;
      $display("FAIL ovf_str: ovf=%b want 1", ovf);
    end
    run(1, 1'b1, 5'd31);
    for (int i = 0; i < 9; i++) wr(1, 8'(8'h30 + i));
    total++;
    if (ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_pat: ovf=%b want 1", ovf);
    end
    run(4, 1'b0, 5'd1);
  endtask

  task automatic test_timeout();
    wr_s(0, "q");
    wr_s(1, ".");
    run(0, 1'b1, 5'd5);
  endtask

  task automatic test_boundary();
    wr_s(1, "^a*$");
    run(TO, 1'b1, 5'd17);
  endtask

  task automatic test_random();
    string cs = "^$*.abxyz";
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 9) < 7) begin
        int l = $urandom_range(1, 34);
        for (int i = 0; i < l; i++)
          wr(0, cs[$urandom_range(0, cs.len() - 1)]);
      end
      if ($urandom_range(0, 9) < 8) begin
        int l = $urandom_range(1, 9);
        for (int i = 0; i < l; i++)
          wr(1, cs[$urandom_range(0, cs.len() - 1)]);
      end
      run($urandom_range(0, TO + 1), 1'($urandom),
          5'($urandom));
    end
  endtask

  task automatic test_reset_mid();
    wr_s(0, "abc");
    wr_s(1, "def");
    start = 1;
    step();
    start = 0;
    repeat (3) step();
    total++;
    if (ispattern !== 1'b1 || chardata !== 8'h64) begin
      bad++;
      $display("FAIL pre_rst: p=%b c=%h want 1 64",
               ispattern, chardata);
    end
    #2 rst_n = 0;
    #1;
    total++;
    if ({busy, ovf, isstring, ispattern, chardata, res_valid,
         res_match, res_index, res_timeout} !== '0) begin
      bad++;
      $display("FAIL mid_rst: outputs not zero");
    end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if ({res_valid, busy} !== 2'b00) begin
        bad++;
        $display("FAIL post_rst[%0d]: rv,busy=%b%b want 00",
                 i, res_valid, busy);
      end
    end
    run(2, 1'b0, 5'd0);
    wr_s(0, "hello");
    wr_s(1, "l*o");
    run(1, 1'b1, 5'd2);
  endtask

  initial begin
    test_reset();
    test_err_start();
    test_basic();
    test_pat_only();
    test_overflow();
    test_timeout();
    test_boundary();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
